frame_fill_ctrl: RTL and testbench

- Sequences filling of a double-buffered 12-bit frame memory: per frame, writes 4 sync-marker words, then data words popped from the upstream digitalFIFO.
- Writes always go to the bank not currently being read.
- A reader-side bank toggle (bufSwitch) restarts filling in the other bank.
- Sits between the word-capture FIFO and the frame RAM write port; sole owner of FIFO rdreq and the RAM write strobe.

---
 rtl/frame_fill_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_frame_fill_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_fill_ctrl.sv
// frame_fill_ctrl: per frame, writes 4 sync-marker words then FIFO data words into the bank of a
// double-buffered frame RAM that the reader is not using. Optional macro FILL_CTRL_STATS_EN adds frame_cnt/abort_cnt.
module frame_fill_ctrl #(
  parameter int FRAME_LEN = 512,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bufSwitch,
  input  logic              fifo_empty,
  input  logic [11:0]       fifo_q,
  output logic              fifo_rdreq,
  output logic [11:0]       outWDAT,
  output logic              outWREN,
  output logic [ADDR_W-1:0] outWADR,
  output logic              frame_done,
  output logic              busy
`ifdef FILL_CTRL_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        abort_cnt
`endif
);

  localparam int                OFF_W     = ADDR_W - 1;
  localparam logic [30:0]       MARK_M    = 31'b1111100110100100001010111011000;
  localparam logic [12:0]       MARK_B    = 13'b1111100110101;
  localparam logic [OFF_W-1:0]  LAST_OFF  = OFF_W'(FRAME_LEN - 1);
  localparam logic [OFF_W-1:0]  MARK_LAST = OFF_W'(3);

  typedef enum logic [1:0] {MARK, REQ, CAP, DONE} state_t;

  state_t             state_q, state_d;
  logic               bs_meta_q, bs_s_q, bs_dly_q;
  logic               bank_q, bank_d;
  logic [1:0]         group_q, group_d;
  logic [OFF_W-1:0]   offset_q, offset_d;
  logic               cap_ph_q, cap_ph_d;
  logic               rdreq_q, rdreq_d;
  logic [11:0]        wdat_q, wdat_d;
  logic               wren_q, wren_d;
  logic [ADDR_W-1:0]  wadr_q, wadr_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               bank_chg;
  logic               last_wr;
  logic               abort;

  // Group g: even groups use M, odd use ~M; groups 0/1 use B, groups 2/3 use ~B.
  function automatic logic [11:0] marker_word(input logic [1:0] g, input logic [1:0] idx);
    logic [30:0] m;
    logic [12:0] b;
    logic [10:0] w;
    m = g[0] ? ~MARK_M : MARK_M;
    b = g[1] ? ~MARK_B : MARK_B;
    case (idx)
      2'd0:    w = m[30:20];
      2'd1:    w = m[19:9];
      2'd2:    w = {m[8:0], b[12:11]};
      default: w = b[10:0];
    endcase
    return {1'b0, w};
  endfunction

  assign bank_chg = (bs_s_q != bs_dly_q);
  assign last_wr  = (state_q == CAP) && cap_ph_q && (offset_q == LAST_OFF);
  assign abort    = bank_chg && (state_q != DONE) && !last_wr;

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    group_d  = group_q;
    offset_d = offset_q;
    cap_ph_d = cap_ph_q;
    rdreq_d  = 1'b0;
    wren_d   = 1'b0;
    done_d   = 1'b0;
    wdat_d   = wdat_q;
    wadr_d   = wadr_q;
    busy_d   = 1'b0;

    unique case (state_q)
      MARK: begin
        wren_d   = 1'b1;
        wadr_d   = {bank_q, offset_q};
        wdat_d   = marker_word(group_q, offset_q[1:0]);
        offset_d = offset_q + OFF_W'(1);
        if (offset_q == MARK_LAST) state_d = REQ;
      end
      REQ: begin
        if (!fifo_empty) begin
          rdreq_d  = 1'b1;
          cap_ph_d = 1'b0;
          state_d  = CAP;
        end
      end
      CAP: begin
        // First CAP cycle lets the FIFO present the popped word; the second writes it.
        if (!cap_ph_q) begin
          cap_ph_d = 1'b1;
        end else begin
          wren_d = 1'b1;
          wadr_d = {bank_q, offset_q};
          wdat_d = fifo_q;
          if (last_wr) begin
            done_d  = 1'b1;
            group_d = group_q + 2'd1;
            state_d = DONE;
          end else begin
            offset_d = offset_q + OFF_W'(1);
            state_d  = REQ;
          end
        end
      end
      DONE: begin
      end
    endcase

    // A reader bank toggle restarts filling; a frame completing on the same cycle still lands.
    if (bank_chg) begin
      state_d  = MARK;
      offset_d = '0;
      cap_ph_d = 1'b0;
      bank_d   = ~bs_s_q;
      rdreq_d  = 1'b0;
      if (!last_wr) begin
        wren_d = 1'b0;
        wdat_d = wdat_q;
        wadr_d = wadr_q;
      end
    end

    busy_d = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MARK;
      bs_meta_q <= 1'b0;
      bs_s_q    <= 1'b0;
      bs_dly_q  <= 1'b0;
      bank_q    <= 1'b1;
      group_q   <= 2'd0;
      offset_q  <= '0;
      cap_ph_q  <= 1'b0;
      rdreq_q   <= 1'b0;
      wdat_q    <= '0;
      wren_q    <= 1'b0;
      wadr_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bs_meta_q <= bufSwitch;
      bs_s_q    <= bs_meta_q;
      bs_dly_q  <= bs_s_q;
      bank_q    <= bank_d;
      group_q   <= group_d;
      offset_q  <= offset_d;
      cap_ph_q  <= cap_ph_d;
      rdreq_q   <= rdreq_d;
      wdat_q    <= wdat_d;
      wren_q    <= wren_d;
      wadr_q    <= wadr_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign fifo_rdreq = rdreq_q;
  assign outWDAT    = wdat_q;
  assign outWREN    = wren_q;
  assign outWADR    = wadr_q;
  assign frame_done = done_q;
  assign busy       = busy_q;

`ifdef FILL_CTRL_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  abort_cnt_q, abort_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    abort_cnt_d = abort_cnt_q;
    if (done_d) frame_cnt_d = frame_cnt_q + 16'd1;
    if (abort && (abort_cnt_q != 8'hFF)) abort_cnt_d = abort_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      abort_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign abort_cnt = abort_cnt_q;
`else
  logic unused_abort;
  assign unused_abort = abort;
`endif

endmodule

// File: tb/tb_frame_fill_ctrl.sv
// Bench for frame_fill_ctrl: cycle table after reset, directed corner sequences, then random FIFO timing
// checked against a frame-level model (markers per group, data in push order, alternating banks).
`timescale 1ns/1ps
module tb_frame_fill_ctrl;
  localparam int FRAME_LEN = 8;
  localparam int ADDR_W    = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              bufSwitch = 1'b0;
  logic              fifo_empty;
  logic [11:0]       fifo_q = 12'h000;
  logic              fifo_rdreq;
  logic [11:0]       outWDAT;
  logic              outWREN;
  logic [ADDR_W-1:0] outWADR;
  logic              frame_done;
  logic              busy;
`ifdef FILL_CTRL_STATS_EN
  logic [15:0]       frame_cnt;
  logic [7:0]        abort_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;

  always #5 clk = ~clk;

  frame_fill_ctrl #(.FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .bufSwitch(bufSwitch),
    .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq),
    .outWDAT(outWDAT), .outWREN(outWREN), .outWADR(outWADR),
    .frame_done(frame_done), .busy(busy)
`ifdef FILL_CTRL_STATS_EN
    , .frame_cnt(frame_cnt), .abort_cnt(abort_cnt)
`endif
  );

  // Upstream FIFO: data appears on fifo_q the cycle after a pop request.
  logic [11:0] fmem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rdreq && (wr_ptr != rd_ptr)) begin
      fifo_q <= fmem[rd_ptr % 256];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (!reset && fifo_rdreq && fifo_empty) viol++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [11:0] v);
    fmem[wr_ptr % 256] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] marker(input int g, input int i);
    logic [11:0] t [16];
    t = '{12'h7CD, 12'h10A, 12'h763, 12'h735,
          12'h032, 12'h6F5, 12'h09F, 12'h735,
          12'h7CD, 12'h10A, 12'h760, 12'h0CA,
          12'h032, 12'h6F5, 12'h09C, 12'h0CA};
    return t[(g % 4) * 4 + i];
  endfunction

  task automatic wait_write(input string name, input int budget, output logic [ADDR_W-1:0] a,
                            output logic [11:0] d, output logic dn, output bit ok);
    a = '0; d = '0; dn = 1'b0; ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (outWREN) begin
        a = outWADR; d = outWDAT; dn = frame_done; ok = 1'b1;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s: no write within %0d cycles", name, budget);
  endtask

  task automatic expect_write(input string name, input logic [ADDR_W-1:0] ea, input logic [11:0] ed,
                              input logic edn);
    logic [ADDR_W-1:0] a;
    logic [11:0] d;
    logic dn;
    bit ok;
    wait_write(name, 40, a, d, dn, ok);
    if (ok) begin
      chk({name, "_adr"}, 32'(a), 32'(ea));
      chk({name, "_dat"}, 32'(d), 32'(ed));
      chk({name, "_done"}, 32'(dn), 32'(edn));
    end
  endtask

  typedef struct {
    logic              push;
    logic [11:0]       pval;
    logic              wren;
    logic [ADDR_W-1:0] adr;
    logic [11:0]       dat;
    logic              rdreq;
    logic              done;
    logic              busy;
  } vec_t;

  vec_t tbl [11];

  logic [11:0] model_data [$];
  int cnt_w, cnt_r, cnt_b;
  int g, widx, cyc, pushed;
  logic bank;
  logic [11:0] ed;
  logic [ADDR_W-1:0] ea;

  initial begin
    tbl[0]  = '{1'b0, 12'h000, 1'b1, 10'h200, 12'h7CD, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 12'h000, 1'b1, 10'h201, 12'h10A, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 12'h000, 1'b1, 10'h202, 12'h763, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 12'h000, 1'b1, 10'h203, 12'h735, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 12'h000, 1'b0, 10'h000, 12'h000, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 12'h000, 1'b0, 10'h000, 12'h000, 1'b0, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 12'h000, 1'b1, 10'h204, 12'h123, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 12'h000, 1'b0, 10'h000, 12'h000, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 12'h456, 1'b0, 10'h000, 12'h000, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 12'h000, 1'b0, 10'h000, 12'h000, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 12'h000, 1'b1, 10'h205, 12'h456, 1'b0, 1'b0, 1'b1};

    // Reset with a word already waiting in the FIFO.
    reset = 1'b1;
    bufSwitch = 1'b0;
    repeat (3) @(negedge clk);
    push(12'h123);
    @(negedge clk);
    chk("rst_wren", 32'(outWREN), 0);
    chk("rst_rdreq", 32'(fifo_rdreq), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wadr", 32'(outWADR), 0);
    chk("rst_wdat", 32'(outWDAT), 0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].push) push(tbl[i].pval);
      @(negedge clk);
      $display("vec %0d: wren=%0b adr=0x%0h dat=0x%0h rdreq=%0b done=%0b busy=%0b",
               i, outWREN, outWADR, outWDAT, fifo_rdreq, frame_done, busy);
      chk($sformatf("vec%0d_wren", i), 32'(outWREN), 32'(tbl[i].wren));
      chk($sformatf("vec%0d_rdreq", i), 32'(fifo_rdreq), 32'(tbl[i].rdreq));
      chk($sformatf("vec%0d_done", i), 32'(frame_done), 32'(tbl[i].done));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      if (tbl[i].wren) begin
        chk($sformatf("vec%0d_adr", i), 32'(outWADR), 32'(tbl[i].adr));
        chk($sformatf("vec%0d_dat", i), 32'(outWDAT), 32'(tbl[i].dat));
      end
    end

    // Finish frame 0; frame_done with the last write, then idle even with data waiting.
    push(12'h789);
    push(12'hABC);
    expect_write("f0_d2", 10'h206, 12'h789, 1'b0);
    expect_write("f0_d3", 10'h207, 12'hABC, 1'b1);
    push(12'h111);
    push(12'h222);
    cnt_w = 0; cnt_r = 0; cnt_b = 0;
    repeat (6) begin
      @(negedge clk);
      if (outWREN) cnt_w++;
      if (fifo_rdreq) cnt_r++;
      if (busy) cnt_b++;
    end
    chk("done_idle_wren", 32'(cnt_w), 0);
    chk("done_idle_rdreq", 32'(cnt_r), 0);
    chk("done_idle_busy", 32'(cnt_b), 0);

    // Reader flips to bank 1: group 1 frame in bank 0.
    bufSwitch = 1'b1;
    for (int i = 0; i < 4; i++)
      expect_write($sformatf("f1_m%0d", i), ADDR_W'(i), marker(1, i), 1'b0);
    expect_write("f1_d0", 10'h004, 12'h111, 1'b0);
    expect_write("f1_d1", 10'h005, 12'h222, 1'b0);

    // FIFO empty in REQ: nothing happens until a push.
    cnt_w = 0; cnt_r = 0;
    repeat (50) begin
      @(negedge clk);
      if (outWREN) cnt_w++;
      if (fifo_rdreq) cnt_r++;
    end
    chk("empty_wait_wren", 32'(cnt_w), 0);
    chk("empty_wait_rdreq", 32'(cnt_r), 0);
    push(12'h333);
    @(negedge clk);
    chk("push_to_rdreq", 32'(fifo_rdreq), 1);
    expect_write("f1_d2", 10'h006, 12'h333, 1'b0);

    // Bank change lands in the rdreq cycle of the final word: word dropped, frame restarts.
    bufSwitch = 1'b0;
    @(negedge clk);
    push(12'h444);
    @(negedge clk);
    chk("abort_rdreq_align", 32'(fifo_rdreq), 1);
    expect_write("abort_restart", 10'h200, 12'h032, 1'b0);
`ifdef FILL_CTRL_STATS_EN
    chk("abort_cnt_1", 32'(abort_cnt), 1);
    chk("frame_cnt_1", 32'(frame_cnt), 1);
`endif
    for (int i = 1; i < 4; i++)
      expect_write($sformatf("f1r_m%0d", i), ADDR_W'(32'h200 + i), marker(1, i), 1'b0);
    push(12'h555); push(12'h666); push(12'h777); push(12'h888);
    expect_write("f1r_d0", 10'h204, 12'h555, 1'b0);
    expect_write("f1r_d1", 10'h205, 12'h666, 1'b0);
    expect_write("f1r_d2", 10'h206, 12'h777, 1'b0);
    expect_write("f1r_d3", 10'h207, 12'h888, 1'b1);

    // Group 2 frame in bank 0, interrupted by reset after one data word.
    bufSwitch = 1'b1;
    for (int i = 0; i < 4; i++)
      expect_write($sformatf("f2_m%0d", i), ADDR_W'(i), marker(2, i), 1'b0);
    push(12'h999);
    expect_write("f2_d0", 10'h004, 12'h999, 1'b0);
    reset = 1'b1;
    bufSwitch = 1'b0;
    @(negedge clk);
    chk("midrst_wren", 32'(outWREN), 0);
    chk("midrst_rdreq", 32'(fifo_rdreq), 0);
    chk("midrst_done", 32'(frame_done), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_wadr", 32'(outWADR), 0);
    chk("midrst_wdat", 32'(outWDAT), 0);
`ifdef FILL_CTRL_STATS_EN
    chk("midrst_frame_cnt", 32'(frame_cnt), 0);
    chk("midrst_abort_cnt", 32'(abort_cnt), 0);
`endif
    reset = 1'b0;

    // Random FIFO arrival: consecutive full frames from group 0 in bank 1, reader flips after each.
    pushed = 0;
    for (int f = 0; f < 8; f++) begin
      g = f % 4;
      bank = ~bufSwitch;
      widx = 0;
      cyc = 0;
      while (widx < FRAME_LEN && cyc < 400) begin
        if (pushed < (f + 1) * (FRAME_LEN - 4) && $urandom_range(0, 2) == 0) begin
          ed = 12'($urandom_range(0, 4095));
          push(ed);
          model_data.push_back(ed);
          pushed++;
        end
        @(negedge clk);
        cyc++;
        if (outWREN) begin
          ea = {bank, (ADDR_W-1)'(widx)};
          if (widx < 4) begin
            ed = marker(g, widx);
          end else if (model_data.size() > 0) begin
            ed = model_data.pop_front();
          end else begin
            ed = 12'h000;
            n_checks++;
            n_fail++;
            $display("FAIL rnd_f%0d_w%0d: data write with nothing pushed, got 0x%0h", f, widx, outWDAT);
          end
          $display("rnd frame %0d word %0d: adr=0x%0h dat=0x%0h done=%0b", f, widx, outWADR, outWDAT, frame_done);
          chk($sformatf("rnd_f%0d_w%0d_adr", f, widx), 32'(outWADR), 32'(ea));
          chk($sformatf("rnd_f%0d_w%0d_dat", f, widx), 32'(outWDAT), 32'(ed));
          chk($sformatf("rnd_f%0d_w%0d_done", f, widx), 32'(frame_done), 32'(widx == FRAME_LEN - 1));
          widx++;
        end
      end
      if (widx < FRAME_LEN) begin
        n_checks++;
        n_fail++;
        $display("FAIL rnd_f%0d_timeout: %0d of %0d words written", f, widx, FRAME_LEN);
        break;
      end
      if (f == 0) chk("rnd_busy_after_done", 32'(busy), 0);
`ifdef FILL_CTRL_STATS_EN
      if (f == 3) chk("rnd_frame_cnt_4", 32'(frame_cnt), 4);
`endif
      bufSwitch = ~bufSwitch;
    end

    chk("rdreq_while_empty", 32'(viol), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
